// File: rtl/lc3b_types.sv
// Shared LC-3b types plus the memory-request record used by the instruction/data memory arbiter.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_INST,
    ARB_DATA
  } lc3b_arb_state;

  typedef struct packed {
    logic          rd;
    logic          wr;
    lc3b_word      addr;
    lc3b_word      wdata;
    lc3b_mem_wmask be;
  } lc3b_mem_req;

  // A port raising both read and write is treated as a write.
  function automatic lc3b_mem_req make_req(input logic          rd,
                                           input logic          wr,
                                           input lc3b_word      addr,
                                           input lc3b_word      wdata,
                                           input lc3b_mem_wmask be);
    lc3b_mem_req r;
    r.rd    = rd & ~wr;
    r.wr    = wr;
    r.addr  = addr;
    r.wdata = wdata;
    r.be    = be;
    return r;
  endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating streak counter: clear has priority over increment, holds at MAX_COUNT.
module arb_starve_counter #(
  parameter int MAX_COUNT = 4,
  parameter int CW        = $clog2(MAX_COUNT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CW'(MAX_COUNT))) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one physical memory port between the CPU instruction and data ports.
// Data wins ties, except after MAX_STARVE consecutive data grants while fetch waited.
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int MAX_STARVE = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inst_mem_read,
  input  logic          inst_mem_write,
  input  lc3b_word      inst_mem_addr,
  input  lc3b_word      inst_mem_wdata,
  input  lc3b_mem_wmask inst_mem_byte_enable,
  output logic          inst_mem_resp,
  output lc3b_word      inst_mem_rdata,
  input  logic          data_mem_read,
  input  logic          data_mem_write,
  input  lc3b_word      data_mem_addr,
  input  lc3b_word      data_mem_wdata,
  input  lc3b_mem_wmask data_mem_byte_enable,
  output logic          data_mem_resp,
  output lc3b_word      data_mem_rdata,
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_word      pmem_addr,
  output lc3b_word      pmem_wdata,
  output lc3b_mem_wmask pmem_byte_enable,
  input  logic          pmem_resp,
  input  lc3b_word      pmem_rdata
);

  localparam int SW = $clog2(MAX_STARVE + 1);

  lc3b_arb_state state;
  lc3b_mem_req   pmem_req;
  lc3b_mem_req   inst_req;
  lc3b_mem_req   data_req;
  logic [SW-1:0] streak;
  logic          req_inst;
  logic          req_data;
  logic          grant_inst;
  logic          grant_data;
  logic          streak_clr;
  logic          streak_inc;

  assign inst_req = make_req(inst_mem_read, inst_mem_write, inst_mem_addr,
                             inst_mem_wdata, inst_mem_byte_enable);
  assign data_req = make_req(data_mem_read, data_mem_write, data_mem_addr,
                             data_mem_wdata, data_mem_byte_enable);

  always_comb begin
    req_inst   = inst_mem_read | inst_mem_write;
    req_data   = data_mem_read | data_mem_write;
    grant_inst = req_inst & (~req_data | (streak == SW'(MAX_STARVE)));
    grant_data = req_data & ~grant_inst;
    streak_clr = (state == ARB_IDLE) & (~req_inst | grant_inst);
    streak_inc = (state == ARB_IDLE) & grant_data & req_inst;
  end

  arb_starve_counter #(
    .MAX_COUNT (MAX_STARVE),
    .CW        (SW)
  ) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (streak_clr),
    .inc   (streak_inc),
    .count (streak)
  );

  // Grant in IDLE latches the winner; the request is then held until pmem_resp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      pmem_req <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_inst) begin
            state    <= ARB_INST;
            pmem_req <= inst_req;
          end else if (grant_data) begin
            state    <= ARB_DATA;
            pmem_req <= data_req;
          end
        end
        ARB_INST, ARB_DATA: begin
          if (pmem_resp) begin
            state       <= ARB_IDLE;
            pmem_req.rd <= 1'b0;
            pmem_req.wr <= 1'b0;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign pmem_read        = pmem_req.rd;
  assign pmem_write       = pmem_req.wr;
  assign pmem_addr        = pmem_req.addr;
  assign pmem_wdata       = pmem_req.wdata;
  assign pmem_byte_enable = pmem_req.be;

  assign inst_mem_resp  = (state == ARB_INST) & pmem_resp;
  assign data_mem_resp  = (state == ARB_DATA) & pmem_resp;
  assign inst_mem_rdata = pmem_rdata;
  assign data_mem_rdata = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int MAX_STARVE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_mem_read = 1'b0, inst_mem_write = 1'b0;
  logic [15:0] inst_mem_addr = '0, inst_mem_wdata = '0;
  logic [1:0]  inst_mem_byte_enable = '0;
  logic        inst_mem_resp;
  logic [15:0] inst_mem_rdata;
  logic        data_mem_read = 1'b0, data_mem_write = 1'b0;
  logic [15:0] data_mem_addr = '0, data_mem_wdata = '0;
  logic [1:0]  data_mem_byte_enable = '0;
  logic        data_mem_resp;
  logic [15:0] data_mem_rdata;
  logic        pmem_read, pmem_write;
  logic [15:0] pmem_addr, pmem_wdata;
  logic [1:0]  pmem_byte_enable;
  logic        pmem_resp = 1'b0;
  logic [15:0] pmem_rdata = '0;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_on  = 1'b0;

  mem_arbiter #(.MAX_STARVE(MAX_STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_mem_read(inst_mem_read), .inst_mem_write(inst_mem_write),
    .inst_mem_addr(inst_mem_addr), .inst_mem_wdata(inst_mem_wdata),
    .inst_mem_byte_enable(inst_mem_byte_enable),
    .inst_mem_resp(inst_mem_resp), .inst_mem_rdata(inst_mem_rdata),
    .data_mem_read(data_mem_read), .data_mem_write(data_mem_write),
    .data_mem_addr(data_mem_addr), .data_mem_wdata(data_mem_wdata),
    .data_mem_byte_enable(data_mem_byte_enable),
    .data_mem_resp(data_mem_resp), .data_mem_rdata(data_mem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
  endfunction

  // Reference model: owner of the physical port (0 none, 1 inst, 2 data),
  // the request captured when ownership was won, and the fetch starvation streak.
  int          m_owner  = 0;
  int          m_streak = 0;
  logic        m_rd = 1'b0, m_wr = 1'b0;
  logic [15:0] m_addr = '0, m_wdata = '0;
  logic [1:0]  m_be = '0;

  always @(posedge clk or negedge rst_n) begin
    bit wi, wd;
    if (!rst_n) begin
      m_owner = 0; m_streak = 0; m_rd = 0; m_wr = 0;
      m_addr = '0; m_wdata = '0; m_be = '0;
    end else if (m_owner == 0) begin
      wi = inst_mem_read | inst_mem_write;
      wd = data_mem_read | data_mem_write;
      if (wi && (!wd || m_streak >= MAX_STARVE)) begin
        m_owner = 1; m_streak = 0;
        m_wr = inst_mem_write; m_rd = inst_mem_read & ~inst_mem_write;
        m_addr = inst_mem_addr; m_wdata = inst_mem_wdata; m_be = inst_mem_byte_enable;
      end else if (wd) begin
        m_owner = 2;
        m_streak = wi ? ((m_streak + 1 > MAX_STARVE) ? MAX_STARVE : m_streak + 1) : 0;
        m_wr = data_mem_write; m_rd = data_mem_read & ~data_mem_write;
        m_addr = data_mem_addr; m_wdata = data_mem_wdata; m_be = data_mem_byte_enable;
      end else begin
        m_streak = 0;
      end
    end else if (pmem_resp) begin
      m_owner = 0; m_rd = 0; m_wr = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("pmem_read",  32'(pmem_read),  32'(m_rd));
      chk("pmem_write", 32'(pmem_write), 32'(m_wr));
      chk("pmem_addr",  32'(pmem_addr),  32'(m_addr));
      chk("pmem_wdata", 32'(pmem_wdata), 32'(m_wdata));
      chk("pmem_be",    32'(pmem_byte_enable), 32'(m_be));
      chk("inst_resp",  32'(inst_mem_resp), 32'(rst_n && m_owner == 1 && pmem_resp));
      chk("data_resp",  32'(data_mem_resp), 32'(rst_n && m_owner == 2 && pmem_resp));
      chk("inst_rdata", 32'(inst_mem_rdata), 32'(pmem_rdata));
      chk("data_rdata", 32'(data_mem_rdata), 32'(pmem_rdata));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for the next physical request, completes it, reports its address and which port got resp.
  task automatic serve_one(output logic [15:0] g_addr, output logic g_inst, output logic g_data);
    int n = 0;
    while (!(pmem_read | pmem_write) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("grant_timeout", 32'(0), 32'(1));
    g_addr = pmem_addr;
    pmem_resp = 1'b1;
    pmem_rdata = 16'($urandom);
    #1;
    g_inst = inst_mem_resp;
    g_data = data_mem_resp;
    tick();
    pmem_resp = 1'b0;
  endtask

  logic [15:0] ga;
  logic        gi, gd;
  bit          ip = 0, dp = 0, i_got = 0, d_got = 0;
  int          lat = 0;
  int          k;

  initial begin
    // reset state
    tick();
    chk_on = 1'b1;
    tick();
    chk("rst_pmem_read", 32'(pmem_read), 32'(0));
    chk("rst_pmem_addr", 32'(pmem_addr), 32'(0));
    chk("rst_resp", 32'({inst_mem_resp, data_mem_resp}), 32'(0));
    rst_n = 1'b1;
    tick();

    // lone instruction read
    inst_mem_read = 1'b1; inst_mem_addr = 16'h1000;
    tick();
    chk("t2_pmem_read", 32'(pmem_read), 32'(1));
    chk("t2_pmem_addr", 32'(pmem_addr), 32'h1000);
    tick(); tick();
    chk("t2_no_early_resp", 32'(inst_mem_resp), 32'(0));
    pmem_resp = 1'b1; pmem_rdata = 16'hBEEF;
    #1;
    chk("t2_inst_resp", 32'(inst_mem_resp), 32'(1));
    chk("t2_inst_rdata", 32'(inst_mem_rdata), 32'hBEEF);
    chk("t2_data_resp", 32'(data_mem_resp), 32'(0));
    tick();
    pmem_resp = 1'b0; inst_mem_read = 1'b0;
    chk("t2_bubble", 32'(pmem_read), 32'(0));
    tick();

    // simultaneous requests: data write first, then fetch
    inst_mem_read = 1'b1; inst_mem_addr = 16'h0040;
    data_mem_write = 1'b1; data_mem_addr = 16'h2001;
    data_mem_wdata = 16'hAB00; data_mem_byte_enable = 2'b10;
    tick();
    chk("t3_write", 32'({pmem_read, pmem_write}), 32'b01);
    chk("t3_addr", 32'(pmem_addr), 32'h2001);
    chk("t3_wdata", 32'(pmem_wdata), 32'hAB00);
    chk("t3_be", 32'(pmem_byte_enable), 32'b10);
    pmem_resp = 1'b1;
    #1;
    chk("t3_data_resp", 32'({inst_mem_resp, data_mem_resp}), 32'b01);
    tick();
    pmem_resp = 1'b0; data_mem_write = 1'b0;
    tick();
    chk("t3_inst_read", 32'({pmem_read, pmem_write}), 32'b10);
    chk("t3_inst_addr", 32'(pmem_addr), 32'h0040);
    pmem_resp = 1'b1;
    #1;
    chk("t3_inst_resp", 32'({inst_mem_resp, data_mem_resp}), 32'b10);
    tick();
    pmem_resp = 1'b0; inst_mem_read = 1'b0;
    tick();

    // starvation guard: expected order DATA, DATA, INST, DATA
    inst_mem_read = 1'b1; inst_mem_addr = 16'h0100;
    data_mem_read = 1'b1; data_mem_addr = 16'h0200;
    for (int g = 0; g < 4; g++) begin
      serve_one(ga, gi, gd);
      chk("t4_grant_addr", 32'(ga), (g == 2) ? 32'h0100 : 32'h0200);
      chk("t4_resp_owner", 32'({gi, gd}), (g == 2) ? 32'b10 : 32'b01);
    end
    inst_mem_read = 1'b0; data_mem_read = 1'b0;
    tick(); tick();

    // reset in the middle of a data transaction
    data_mem_read = 1'b1; data_mem_addr = 16'h3000;
    tick();
    chk("t5_granted", 32'(pmem_read), 32'(1));
    #2;
    rst_n = 1'b0; data_mem_read = 1'b0;
    #1;
    chk("t5_async_pmem", 32'({pmem_read, pmem_write, pmem_addr, pmem_wdata, pmem_byte_enable}), 32'(0));
    chk("t5_async_resp", 32'({inst_mem_resp, data_mem_resp}), 32'(0));
    #2;
    rst_n = 1'b1;
    tick();
    pmem_resp = 1'b1;
    #1;
    chk("t5_late_resp", 32'({inst_mem_resp, data_mem_resp}), 32'(0));
    tick();
    pmem_resp = 1'b0;
    inst_mem_read = 1'b1; inst_mem_addr = 16'h4444;
    tick();
    chk("t5_fresh_grant", 32'({pmem_read, pmem_addr}), 32'h14444);
    pmem_resp = 1'b1;
    #1;
    chk("t5_fresh_resp", 32'(inst_mem_resp), 32'(1));
    tick();
    pmem_resp = 1'b0; inst_mem_read = 1'b0;
    tick();

    // requester address changes after grant are ignored
    data_mem_read = 1'b1; data_mem_addr = 16'h5000;
    tick();
    data_mem_addr = 16'hFFFF;
    tick();
    chk("t6_addr_held", 32'(pmem_addr), 32'h5000);
    tick();
    pmem_resp = 1'b1;
    #1;
    chk("t6_addr_at_resp", 32'(pmem_addr), 32'h5000);
    chk("t6_resp", 32'(data_mem_resp), 32'(1));
    tick();
    pmem_resp = 1'b0; data_mem_read = 1'b0;
    tick();

    // random traffic against the reference model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0; ip = 0; dp = 0; lat = 0; pmem_resp = 1'b0;
        inst_mem_read = 0; inst_mem_write = 0; data_mem_read = 0; data_mem_write = 0;
        #2;
        rst_n = 1'b1;
        tick();
        continue;
      end
      if (i_got) begin ip = 0; inst_mem_read = 0; inst_mem_write = 0; end
      if (d_got) begin dp = 0; data_mem_read = 0; data_mem_write = 0; end
      if (!ip && $urandom_range(0, 2) == 0) begin
        ip = 1; k = $urandom_range(0, 9);
        inst_mem_read = (k < 7) || (k == 9); inst_mem_write = (k >= 7);
        inst_mem_addr = 16'($urandom); inst_mem_wdata = 16'($urandom);
        inst_mem_byte_enable = 2'($urandom);
      end else if (ip && $urandom_range(0, 7) == 0) begin
        inst_mem_addr = 16'($urandom); inst_mem_wdata = 16'($urandom);
      end
      if (!dp && $urandom_range(0, 1) == 0) begin
        dp = 1; k = $urandom_range(0, 9);
        data_mem_read = (k < 6) || (k == 9); data_mem_write = (k >= 6);
        data_mem_addr = 16'($urandom); data_mem_wdata = 16'($urandom);
        data_mem_byte_enable = 2'($urandom);
      end else if (dp && $urandom_range(0, 7) == 0) begin
        data_mem_addr = 16'($urandom); data_mem_wdata = 16'($urandom);
      end
      if (pmem_resp) begin
        pmem_resp = 1'b0;
      end else if (pmem_read | pmem_write) begin
        if (lat == 0) begin
          pmem_resp = 1'b1; pmem_rdata = 16'($urandom); lat = $urandom_range(0, 3);
        end else begin
          lat--;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        pmem_resp = 1'b1; pmem_rdata = 16'($urandom);
      end
      #1;
      i_got = inst_mem_resp;
      d_got = data_mem_resp;
      tick();
    end

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
